// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the round-robin RAM arbiter.
package ram_arb_pkg;

  localparam int unsigned NUM_REQ_MAX = 4;
  localparam int unsigned AW_DEF      = 4;
  localparam int unsigned DW_DEF      = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DONE
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request scanning last+1, last+2, ... mod NUM_REQ.
module rr_pick #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned LW      = 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [LW-1:0]      i_last,
  output logic [LW-1:0]      o_grant,
  output logic               o_valid
);

  logic [LW-1:0] w_idx;

  always_comb begin
    o_grant = '0;
    o_valid = 1'b0;
    w_idx   = '0;
    // Offset k=NUM_REQ wraps back to the last winner, so it is only chosen when alone.
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_idx = LW'((32'(i_last) + k) % NUM_REQ);
      if (!o_valid && i_req[w_idx]) begin
        o_grant = w_idx;
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter serialising single-beat reads/writes from NUM_REQ clients onto one RAM.
// Optional per-requester grant counters are built when RAM_ARB_STATS_EN is defined.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned AW      = AW_DEF,
  parameter int unsigned DW      = DW_DEF
`ifdef RAM_ARB_STATS_EN
  ,
  parameter int unsigned CNT_W   = 16
`endif
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ-1:0]      we,
  input  logic [NUM_REQ*AW-1:0]   addr,
  input  logic [NUM_REQ*DW-1:0]   wdata,
  output logic [NUM_REQ-1:0]      ack,
  output logic [DW-1:0]           rdata,
  output logic                    busy,
  output logic                    ram_read,
  output logic                    ram_write,
  output logic [AW-1:0]           ram_raddr,
  output logic [AW-1:0]           ram_waddr,
  output logic [DW-1:0]           ram_wdata,
  input  logic [DW-1:0]           ram_rdata,
  input  logic                    ram_read_ready,
  input  logic                    ram_write_ready
`ifdef RAM_ARB_STATS_EN
  ,
  output logic [NUM_REQ*CNT_W-1:0] grant_cnt
`endif
);

  localparam int unsigned LW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t        r_state;
  state_t        w_next_state;
  logic [LW-1:0] r_last;
  logic [LW-1:0] w_pick;
  logic          w_pick_valid;
  logic          w_take;
  logic          r_we;
  logic [AW-1:0] r_raddr;
  logic [AW-1:0] r_waddr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rdata;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wdata;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .LW      (LW)
  ) u_rr_pick (
    .i_req   (req),
    .i_last  (r_last),
    .o_grant (w_pick),
    .o_valid (w_pick_valid)
  );

  assign w_sel_addr  = addr[w_pick*AW +: AW];
  assign w_sel_wdata = wdata[w_pick*DW +: DW];

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_take       = 1'b0;
    ack          = '0;
    busy         = 1'b1;
    ram_read     = 1'b0;
    ram_write    = 1'b0;
    rdata        = r_rdata;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (w_pick_valid && ram_read_ready && ram_write_ready) begin
          w_take       = 1'b1;
          w_next_state = ISSUE;
        end
      end
      ISSUE: begin
        ram_read     = !r_we;
        ram_write    = r_we;
        w_next_state = DONE;
      end
      DONE: begin
        ack[r_last] = 1'b1;
        // RAM read data arrives this cycle; forward it so it is visible alongside ack.
        if (!r_we) begin
          rdata = ram_rdata;
        end
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_last  <= LW'(NUM_REQ - 1);
      r_we    <= 1'b0;
      r_raddr <= '0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (w_take) begin
        r_last <= w_pick;
        r_we   <= we[w_pick];
        if (we[w_pick]) begin
          r_waddr <= w_sel_addr;
          r_wdata <= w_sel_wdata;
        end else begin
          r_raddr <= w_sel_addr;
        end
      end
      if (r_state == DONE && !r_we) begin
        r_rdata <= ram_rdata;
      end
    end
  end

  assign ram_raddr = r_raddr;
  assign ram_waddr = r_waddr;
  assign ram_wdata = r_wdata;

`ifdef RAM_ARB_STATS_EN
  logic [NUM_REQ-1:0][CNT_W-1:0] r_cnt;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (w_take && (r_cnt[w_pick] != '1)) begin
      r_cnt[w_pick] <= r_cnt[w_pick] + 1'b1;
    end
  end

  assign grant_cnt = r_cnt;
`else
  // No grant statistics in this build.
`endif

endmodule
